// File: rtl/magic_rom_pkg.sv
// Shared constants, command record and engine state for the magic-pattern burst ROM.
package magic_rom_pkg;

  localparam logic [31:0] MAGIC_LOW_DEF  = 32'h53796E63;
  localparam logic [31:0] MAGIC_HIGH_DEF = 32'h5772745F;

  localparam int BEAT_IDX_LSB = 64;
  localparam int SEQ_LSB      = 80;
  localparam int SEQ_W        = 16;

  typedef struct packed {
    logic [SEQ_W-1:0] burstcount;
    logic [SEQ_W-1:0] seq;
  } cmd_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } eng_state_t;

endpackage

// File: rtl/magic_rom_cmd_fifo.sv
// Show-ahead command FIFO; a push and a pop in the same cycle are both honoured when non-empty.
module magic_rom_cmd_fifo
  import magic_rom_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  cmd_t             mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign head      = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end
  end

  // Command storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/magic_pattern_burst_rom.sv
// Avalon-MM burst-read slave answering every beat with the "Wrt_Sync" magic word,
// with up to MAX_PENDING outstanding bursts streamed back-to-back.
module magic_pattern_burst_rom
  import magic_rom_pkg::*;
#(
  parameter int          DATA_WIDTH  = 512,
  parameter int          ADDR_WIDTH  = 2,
  parameter int          BURST_WIDTH = 3,
  parameter int          MAX_PENDING = 4,
  parameter int          SEQ_ENABLE  = 0,
  parameter logic [31:0] MAGIC_LOW   = MAGIC_LOW_DEF,
  parameter logic [31:0] MAGIC_HIGH  = MAGIC_HIGH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic                   read,
  input  logic [BURST_WIDTH-1:0] burst,
  output logic [DATA_WIDTH-1:0]  readdata,
  output logic                   waitrequest,
  output logic                   readdatavalid
);

  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam int FMT_W  = (DATA_WIDTH > 96) ? DATA_WIDTH : 96;
  localparam logic [BURST_WIDTH-1:0] ONE_BEAT = BURST_WIDTH'(1);

  eng_state_t             state_r, state_n;
  logic [BURST_WIDTH-1:0] beat_cnt_r, beat_cnt_n;
  logic [BURST_WIDTH-1:0] beat_idx_r, beat_idx_n;
  logic [SEQ_W-1:0]       cur_seq_r, cur_seq_n;
  logic [SEQ_W-1:0]       seq_r;
  logic [PEND_W-1:0]      pending_r, pending_n;
  logic                   waitrequest_r;
  logic                   readdatavalid_r;
  logic [DATA_WIDTH-1:0]  readdata_r;

  logic                   accept_s, retire_s, load_s, bypass_s, pop_s, push_s, valid_n;
  logic [BURST_WIDTH-1:0] beats_s;
  cmd_t                   push_cmd_s, head_s;
  logic                   fifo_full_s, fifo_empty_s;
  logic [FMT_W-1:0]       fmt_s;
  logic                   unused_s;

  assign accept_s   = read & ~waitrequest_r;
  assign beats_s    = (burst == {BURST_WIDTH{1'b0}}) ? ONE_BEAT : burst;
  assign retire_s   = (state_r == ST_STREAM) && (beat_cnt_r == ONE_BEAT);
  assign pending_n  = pending_r + PEND_W'(accept_s) - PEND_W'(retire_s);
  assign push_s     = accept_s & ~bypass_s;
  assign push_cmd_s = '{burstcount: SEQ_W'(beats_s), seq: seq_r};
  assign unused_s   = ^{address, head_s.burstcount, fifo_full_s};

  magic_rom_cmd_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_cmd_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Response engine: pick the beat to present next cycle; a new burst loads on the last beat.
  always_comb begin
    state_n    = state_r;
    beat_cnt_n = beat_cnt_r;
    beat_idx_n = beat_idx_r;
    cur_seq_n  = cur_seq_r;
    valid_n    = 1'b0;
    load_s     = 1'b0;
    pop_s      = 1'b0;
    bypass_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        load_s = 1'b1;
      end
      ST_STREAM: begin
        if (beat_cnt_r == ONE_BEAT) begin
          load_s = 1'b1;
        end else begin
          beat_cnt_n = beat_cnt_r - ONE_BEAT;
          beat_idx_n = beat_idx_r + ONE_BEAT;
          valid_n    = 1'b1;
        end
      end
      default: begin
        load_s = 1'b1;
      end
    endcase
    // The FIFO head is always older than a same-cycle accept, so it wins.
    if (load_s) begin
      if (!fifo_empty_s) begin
        pop_s      = 1'b1;
        state_n    = ST_STREAM;
        beat_cnt_n = head_s.burstcount[BURST_WIDTH-1:0];
        beat_idx_n = {BURST_WIDTH{1'b0}};
        cur_seq_n  = head_s.seq;
        valid_n    = 1'b1;
      end else if (accept_s) begin
        bypass_s   = 1'b1;
        state_n    = ST_STREAM;
        beat_cnt_n = beats_s;
        beat_idx_n = {BURST_WIDTH{1'b0}};
        cur_seq_n  = seq_r;
        valid_n    = 1'b1;
      end else begin
        state_n    = ST_IDLE;
        beat_cnt_n = {BURST_WIDTH{1'b0}};
      end
    end else begin
      state_n = ST_STREAM;
    end
  end

  // Readdata formatting for the beat about to be presented.
  always_comb begin
    fmt_s = {FMT_W{1'b0}};
    if (valid_n) begin
      fmt_s[31:0]  = MAGIC_LOW;
      fmt_s[63:32] = MAGIC_HIGH;
      if (SEQ_ENABLE != 0) begin
        fmt_s[BEAT_IDX_LSB +: SEQ_W] = SEQ_W'(beat_idx_n);
        fmt_s[SEQ_LSB +: SEQ_W]      = cur_seq_n;
      end else begin
        fmt_s[BEAT_IDX_LSB +: 2*SEQ_W] = {(2*SEQ_W){1'b0}};
      end
    end else begin
      fmt_s = {FMT_W{1'b0}};
    end
  end

  // State, counters and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      beat_cnt_r      <= {BURST_WIDTH{1'b0}};
      beat_idx_r      <= {BURST_WIDTH{1'b0}};
      cur_seq_r       <= {SEQ_W{1'b0}};
      seq_r           <= {SEQ_W{1'b0}};
      pending_r       <= {PEND_W{1'b0}};
      waitrequest_r   <= 1'b1;
      readdatavalid_r <= 1'b0;
      readdata_r      <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r         <= state_n;
      beat_cnt_r      <= beat_cnt_n;
      beat_idx_r      <= beat_idx_n;
      cur_seq_r       <= cur_seq_n;
      seq_r           <= seq_r + SEQ_W'(accept_s);
      pending_r       <= pending_n;
      waitrequest_r   <= (pending_n == PEND_W'(MAX_PENDING));
      readdatavalid_r <= valid_n;
      readdata_r      <= fmt_s[DATA_WIDTH-1:0];
    end
  end

  assign readdata      = readdata_r;
  assign waitrequest   = waitrequest_r;
  assign readdatavalid = readdatavalid_r;

endmodule
